// File: rtl/demux1x4_bit32_buf.sv
// demux1x4_bit32_buf: registered 1:4 word demux; in_data/in_sel/in_valid/in_ready in, port0..3/out_valid/out_ready out, cnt_sel/cnt_out per-port accept counters
module demux1x4_bit32_buf #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] port0,
  output logic [WIDTH-1:0] port1,
  output logic [WIDTH-1:0] port2,
  output logic [WIDTH-1:0] port3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  input  logic [1:0]       cnt_sel,
  output logic [CNT_W-1:0] cnt_out
);
  logic [WIDTH-1:0] port_q [4];
  logic [WIDTH-1:0] port_d [4];
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [3:0]       valid_q, valid_d, hit;
  always_comb begin
    in_ready = !valid_q[in_sel] || out_ready[in_sel];
    hit = (in_valid && in_ready) ? 4'b0001 << in_sel : 4'b0000;
    valid_d = hit | (valid_q & ~out_ready);
    for (int i = 0; i < 4; i++) begin
      port_d[i] = hit[i] ? in_data : port_q[i];
      cnt_d[i] = cnt_q[i] + CNT_W'(hit[i]);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < 4; i++) begin
        port_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < 4; i++) begin
        port_q[i] <= port_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end
  assign port0 = port_q[0];
  assign port1 = port_q[1];
  assign port2 = port_q[2];
  assign port3 = port_q[3];
  assign out_valid = valid_q;
  assign cnt_out = cnt_q[cnt_sel];
endmodule

// File: tb/tb_demux1x4_bit32_buf.sv
// tb_demux1x4_bit32_buf: scenario tasks plus randomized traffic against a buffer/counter model
module tb_demux1x4_bit32_buf;
  logic clk = 0, rst_n = 0;
  logic [31:0] in_data = '0;
  logic [1:0] in_sel = '0, cnt_sel = '0;
  logic in_valid = 0, in_ready;
  logic [31:0] port0, port1, port2, port3;
  logic [3:0] out_valid, out_ready = '0;
  logic [7:0] cnt_out;
  logic [31:0] ports [4];
  assign ports[0] = port0;
  assign ports[1] = port1;
  assign ports[2] = port2;
  assign ports[3] = port3;
  int tests = 0, fails = 0;
  logic [31:0] m_word [4];
  bit m_full [4];
  int m_cnt [4];

  demux1x4_bit32_buf dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready), .port0(port0), .port1(port1), .port2(port2), .port3(port3),
    .out_valid(out_valid), .out_ready(out_ready), .cnt_sel(cnt_sel), .cnt_out(cnt_out)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    for (int p = 0; p < 4; p++) begin
      m_word[p] = '0;
      m_full[p] = 0;
      m_cnt[p] = 0;
    end
  endtask

  task automatic tick();
    bit rdy;
    rdy = !m_full[in_sel] || out_ready[in_sel];
    @(posedge clk);
    for (int p = 0; p < 4; p++)
      if (m_full[p] && out_ready[p]) m_full[p] = 0;
    if (in_valid && rdy) begin
      m_word[in_sel] = in_data;
      m_full[in_sel] = 1;
      m_cnt[in_sel] = (m_cnt[in_sel] + 1) % 256;
    end
    #1;
  endtask

  task automatic do_reset();
    #2 rst_n = 0;
    model_clear();
    #3 rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    out_ready = 4'b0000;
    in_valid = 1; in_sel = 2; in_data = 32'hCAFE_0002;
    tick();
    in_valid = 0;
    tests++;
    if (out_valid !== 4'b0100 || port2 !== 32'hCAFE_0002) begin
      fails++;
      $display("FAIL reset_prefill: out_valid=%b port2=%h want 0100 cafe0002", out_valid, port2);
    end
    #2 rst_n = 0;
    model_clear();
    #1;
    tests++;
    if (out_valid !== 4'b0000 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_state: out_valid=%b in_ready=%b want 0000 1", out_valid, in_ready);
    end
    for (int p = 0; p < 4; p++) begin
      cnt_sel = 2'(p);
      #0.1;
      tests++;
      if (ports[p] !== 32'h0 || cnt_out !== 8'h0) begin
        fails++;
        $display("FAIL reset_port%0d: data=%h cnt=%0d want 0 0", p, ports[p], cnt_out);
      end
    end
    #2 rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic_steer();
    out_ready = 4'b1111;
    in_valid = 1; in_sel = 1; in_data = 32'hDEADBEEF;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL basic_ready: in_ready=%b want 1", in_ready); end
    tick();
    tests++;
    if (out_valid !== 4'b0010 || port1 !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL basic_port1: out_valid=%b port1=%h want 0010 deadbeef", out_valid, port1);
    end
    in_sel = 3; in_data = 32'h12345678;
    tick();
    in_valid = 0;
    tests++;
    if (out_valid !== 4'b1000 || port3 !== 32'h12345678) begin
      fails++;
      $display("FAIL basic_port3: out_valid=%b port3=%h want 1000 12345678", out_valid, port3);
    end
    tick();
    cnt_sel = 1; #1;
    tests++;
    if (cnt_out !== 8'd1) begin fails++; $display("FAIL basic_cnt1: cnt=%0d want 1", cnt_out); end
    cnt_sel = 3; #1;
    tests++;
    if (cnt_out !== 8'd1 || out_valid !== 4'b0000) begin
      fails++;
      $display("FAIL basic_cnt3: cnt=%0d out_valid=%b want 1 0000", cnt_out, out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 4'b1110;
    in_valid = 1; in_sel = 0; in_data = 32'hA;
    tick();
    in_data = 32'hB;
    #1;
    tests++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_stall: in_ready=%b want 0", in_ready); end
    tick();
    tests++;
    if (port0 !== 32'hA || out_valid[0] !== 1'b1) begin
      fails++;
      $display("FAIL bp_hold: port0=%h valid0=%b want a 1", port0, out_valid[0]);
    end
    out_ready = 4'b1111;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release: in_ready=%b want 1", in_ready); end
    tick();
    in_valid = 0;
    tests++;
    if (port0 !== 32'hB || out_valid[0] !== 1'b1) begin
      fails++;
      $display("FAIL bp_next: port0=%h valid0=%b want b 1", port0, out_valid[0]);
    end
    tick();
  endtask

  task automatic test_independence();
    out_ready = 4'b1110;
    in_valid = 1; in_sel = 0; in_data = 32'hA;
    tick();
    for (int k = 1; k <= 3; k++) begin
      in_sel = 2'(k); in_data = 32'(k);
      #1;
      tests++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL indep_ready%0d: in_ready=%b want 1", k, in_ready); end
      tick();
      tests++;
      if (ports[k] !== 32'(k) || port0 !== 32'hA || out_valid[0] !== 1'b1) begin
        fails++;
        $display("FAIL indep_word%0d: port=%h port0=%h want %h a", k, ports[k], port0, k);
      end
    end
    in_valid = 0;
    out_ready = 4'b1111;
    tick();
  endtask

  task automatic test_back_to_back();
    int start;
    start = m_cnt[2];
    out_ready = 4'b1111;
    in_valid = 1; in_sel = 2;
    for (int k = 0; k < 10; k++) begin
      in_data = 32'h100 + 32'(k);
      tick();
      tests++;
      if (out_valid[2] !== 1'b1 || port2 !== 32'h100 + 32'(k)) begin
        fails++;
        $display("FAIL b2b_word%0d: valid2=%b port2=%h want 1 %h", k, out_valid[2], port2, 32'h100 + k);
      end
    end
    in_valid = 0;
    tick();
    cnt_sel = 2; #1;
    tests++;
    if (cnt_out !== 8'((start + 10) % 256)) begin
      fails++;
      $display("FAIL b2b_cnt: cnt=%0d want %0d", cnt_out, (start + 10) % 256);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready = 4'b1111;
    in_valid = 1; in_sel = 3;
    for (int k = 0; k < 257; k++) begin
      in_data = $urandom;
      tick();
    end
    in_valid = 0;
    tick();
    for (int p = 0; p < 4; p++) begin
      cnt_sel = 2'(p); #1;
      tests++;
      if (cnt_out !== (p == 3 ? 8'd1 : 8'd0)) begin
        fails++;
        $display("FAIL wrap_cnt%0d: cnt=%0d want %0d", p, cnt_out, p == 3 ? 1 : 0);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      in_valid = 1'($urandom);
      in_sel = 2'($urandom);
      in_data = $urandom;
      out_ready = 4'($urandom);
      cnt_sel = 2'($urandom);
      #1;
      tests++;
      if (in_ready !== (!m_full[in_sel] || out_ready[in_sel]) || cnt_out !== 8'(m_cnt[cnt_sel])) begin
        fails++;
        $display("FAIL rand_comb%0d: in_ready=%b cnt=%0d want %b %0d", n, in_ready, cnt_out,
                 !m_full[in_sel] || out_ready[in_sel], m_cnt[cnt_sel]);
      end
      tick();
      for (int p = 0; p < 4; p++) begin
        tests++;
        if (out_valid[p] !== m_full[p] || (m_full[p] && ports[p] !== m_word[p])) begin
          fails++;
          $display("FAIL rand_port%0d_%0d: valid=%b data=%h want %b %h", p, n, out_valid[p], ports[p], m_full[p], m_word[p]);
        end
      end
    end
    in_valid = 0;
  endtask

  initial begin
    test_reset();
    test_basic_steer();
    test_backpressure();
    test_independence();
    test_back_to_back();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
